snn_debug_collector: RTL and testbench

Consumes the five serial debug lanes produced by the SPI-to-SNN bridge's debug FIFOs, in the `clk_snn` domain. It deserializes each lane's 16-bit MSB-first frame and rebuilds one access record per frame: write-enable, 9-bit address, 32-bit data-in and 32-bit data-out. Records are offered to a downstream trace sink through a 2-entry valid/ready buffer. The block also keeps saturating record and drop counters, a sticky padding-error flag and a single-address trigger.

---
 rtl/snn_debug_collector.sv | 184 ++++++++++++++++++
 tb/tb_snn_debug_collector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_debug_collector.sv
`default_nettype none
// ============================================================================
// Module   : snn_debug_collector
// Brief    : Deserializes the five debug lanes into access records, buffers
//            them in a 2-entry valid/ready FIFO and keeps trace statistics.
// Revision : 1.0
// ============================================================================
module snn_debug_collector #(
    parameter int FRAME_WIDTH = 16,
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk_snn,
    input  logic                  rst_i,
    input  logic                  debug_en_i,
    input  logic                  ser_valid_i,
    input  logic                  ser_data_out_high_i,
    input  logic                  ser_data_out_low_i,
    input  logic                  ser_data_in_high_i,
    input  logic                  ser_data_in_low_i,
    input  logic                  ser_wr_en_addr_i,
    input  logic                  trig_en_i,
    input  logic [ADDR_WIDTH-1:0] trig_addr_i,
    input  logic                  rec_ready_i,
    output logic                  rec_valid_o,
    output logic                  rec_we_o,
    output logic [ADDR_WIDTH-1:0] rec_addr_o,
    output logic [DATA_WIDTH-1:0] rec_data_in_o,
    output logic [DATA_WIDTH-1:0] rec_data_out_o,
    output logic                  trig_hit_o,
    output logic                  pad_err_o,
    output logic [CNT_WIDTH-1:0]  rec_count_o,
    output logic [CNT_WIDTH-1:0]  drop_count_o,
    output logic                  busy_o
);

    localparam int              CW         = $clog2(FRAME_WIDTH);
    localparam logic [CW-1:0]   FRAME_LAST = CW'(FRAME_WIDTH - 1);
    localparam int              RW         = 1 + ADDR_WIDTH + 2 * DATA_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [FRAME_WIDTH-1:0] out_hi_q, out_hi_d, out_lo_q, out_lo_d;
    logic [FRAME_WIDTH-1:0] in_hi_q, in_hi_d, in_lo_q, in_lo_d;
    logic [FRAME_WIDTH-1:0] wr_q, wr_d;
    logic                   done_q, done_d;

    logic [RW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [1:0]             fill_q, fill_d;
    logic [CNT_WIDTH-1:0]   rec_cnt_q, rec_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                   trig_q, trig_d, pad_q, pad_d;

    logic                   accept;
    logic                   pop, push, drop;
    logic                   new_we;
    logic [ADDR_WIDTH-1:0]  new_addr;
    logic [RW-1:0]          new_rec;

    // Deserializer: shift registers hold a full frame the cycle after its last bit.
    always_comb begin
        state_d  = debug_en_i ? ST_SHIFT : ST_IDLE;
        cnt_d    = cnt_q;
        out_hi_d = out_hi_q;
        out_lo_d = out_lo_q;
        in_hi_d  = in_hi_q;
        in_lo_d  = in_lo_q;
        wr_d     = wr_q;
        accept   = (state_q == ST_SHIFT) && ser_valid_i;
        done_d   = accept && (cnt_q == FRAME_LAST);
        if (state_q == ST_IDLE) begin
            cnt_d    = '0;
            out_hi_d = '0;
            out_lo_d = '0;
            in_hi_d  = '0;
            in_lo_d  = '0;
            wr_d     = '0;
        end else if (accept) begin
            cnt_d    = (cnt_q == FRAME_LAST) ? '0 : cnt_q + 1'b1;
            out_hi_d = {out_hi_q[FRAME_WIDTH-2:0], ser_data_out_high_i};
            out_lo_d = {out_lo_q[FRAME_WIDTH-2:0], ser_data_out_low_i};
            in_hi_d  = {in_hi_q[FRAME_WIDTH-2:0], ser_data_in_high_i};
            in_lo_d  = {in_lo_q[FRAME_WIDTH-2:0], ser_data_in_low_i};
            wr_d     = {wr_q[FRAME_WIDTH-2:0], ser_wr_en_addr_i};
        end
    end

    assign new_we   = wr_q[ADDR_WIDTH];
    assign new_addr = wr_q[ADDR_WIDTH-1:0];
    assign new_rec  = {new_we, new_addr, in_hi_q, in_lo_q, out_hi_q, out_lo_q};

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign pop  = (fill_q != 2'd0) && rec_ready_i;
    assign push = done_q && ((fill_q != 2'd2) || pop);
    assign drop = done_q && !push;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        rec_cnt_d  = rec_cnt_q;
        drop_cnt_d = drop_cnt_q;
        trig_d     = push && trig_en_i && (new_addr == trig_addr_i);
        pad_d      = pad_q | (done_q && (|wr_q[FRAME_WIDTH-1:ADDR_WIDTH+1]));
        if (pop && push) begin
            if (fill_q == 2'd1) begin
                head_d = new_rec;
            end else begin
                head_d = tail_q;
                tail_d = new_rec;
            end
        end else if (pop) begin
            head_d = tail_q;
            fill_d = fill_q - 2'd1;
        end else if (push) begin
            if (fill_q == 2'd0) begin
                head_d = new_rec;
            end else begin
                tail_d = new_rec;
            end
            fill_d = fill_q + 2'd1;
        end
        if (push && (rec_cnt_q != '1)) begin
            rec_cnt_d = rec_cnt_q + 1'b1;
        end
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_snn) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            out_hi_q   <= '0;
            out_lo_q   <= '0;
            in_hi_q    <= '0;
            in_lo_q    <= '0;
            wr_q       <= '0;
            done_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= 2'd0;
            rec_cnt_q  <= '0;
            drop_cnt_q <= '0;
            trig_q     <= 1'b0;
            pad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_hi_q   <= out_hi_d;
            out_lo_q   <= out_lo_d;
            in_hi_q    <= in_hi_d;
            in_lo_q    <= in_lo_d;
            wr_q       <= wr_d;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            rec_cnt_q  <= rec_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            trig_q     <= trig_d;
            pad_q      <= pad_d;
        end
    end

    assign rec_valid_o    = (fill_q != 2'd0);
    assign rec_we_o       = head_q[RW-1];
    assign rec_addr_o     = head_q[RW-2 -: ADDR_WIDTH];
    assign rec_data_in_o  = head_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
    assign rec_data_out_o = head_q[DATA_WIDTH-1:0];
    assign trig_hit_o     = trig_q;
    assign pad_err_o      = pad_q;
    assign rec_count_o    = rec_cnt_q;
    assign drop_count_o   = drop_cnt_q;
    assign busy_o         = (state_q == ST_SHIFT) && (cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_snn_debug_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_debug_collector
// Brief    : Randomized and directed bench with a record-level reference model.
// Revision : 1.0
// ============================================================================
module tb_snn_debug_collector;

    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk_snn = 1'b0;
    logic            rst_i = 1'b0;
    logic            debug_en_i = 1'b0, ser_valid_i = 1'b0;
    logic            ser_data_out_high_i = 1'b0, ser_data_out_low_i = 1'b0;
    logic            ser_data_in_high_i = 1'b0, ser_data_in_low_i = 1'b0;
    logic            ser_wr_en_addr_i = 1'b0;
    logic            trig_en_i = 1'b0;
    logic [8:0]      trig_addr_i = '0;
    logic            rec_ready_i = 1'b0;
    logic            rec_valid_o, rec_we_o, trig_hit_o, pad_err_o, busy_o;
    logic [8:0]      rec_addr_o;
    logic [31:0]     rec_data_in_o, rec_data_out_o;
    logic [CNTW-1:0] rec_count_o, drop_count_o;

    snn_debug_collector #(
        .FRAME_WIDTH(16), .ADDR_WIDTH(9), .DATA_WIDTH(32), .CNT_WIDTH(CNTW)
    ) dut (
        .clk_snn(clk_snn), .rst_i(rst_i), .debug_en_i(debug_en_i),
        .ser_valid_i(ser_valid_i),
        .ser_data_out_high_i(ser_data_out_high_i), .ser_data_out_low_i(ser_data_out_low_i),
        .ser_data_in_high_i(ser_data_in_high_i), .ser_data_in_low_i(ser_data_in_low_i),
        .ser_wr_en_addr_i(ser_wr_en_addr_i), .trig_en_i(trig_en_i),
        .trig_addr_i(trig_addr_i), .rec_ready_i(rec_ready_i),
        .rec_valid_o(rec_valid_o), .rec_we_o(rec_we_o), .rec_addr_o(rec_addr_o),
        .rec_data_in_o(rec_data_in_o), .rec_data_out_o(rec_data_out_o),
        .trig_hit_o(trig_hit_o), .pad_err_o(pad_err_o),
        .rec_count_o(rec_count_o), .drop_count_o(drop_count_o), .busy_o(busy_o)
    );

    always #5 clk_snn = ~clk_snn;

    typedef struct packed {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] din;
        logic [31:0] dout;
    } rec_t;

    int    checks = 0;
    int    errors = 0;
    bit    cmp_on = 1'b0;

    // Reference model: lanes collected as whole words, records in a queue.
    bit          m_shift;
    int          m_nb;
    logic [15:0] m_acc  [5];
    logic [15:0] m_prec [5];
    bit          m_pend;
    rec_t        m_q [$];
    int          m_rc, m_dc;
    bit          m_pad, m_trig;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [4:0] lane;
        rec_t       r;
        if (!rst_i) begin
            m_shift = 0; m_nb = 0; m_pend = 0; m_rc = 0; m_dc = 0;
            m_pad = 0; m_trig = 0; m_q.delete();
            for (int k = 0; k < 5; k++) begin m_acc[k] = '0; m_prec[k] = '0; end
            return;
        end
        m_trig = 0;
        if (m_q.size() > 0 && rec_ready_i) void'(m_q.pop_front());
        if (m_pend) begin
            r.we   = m_prec[4][9];
            r.addr = m_prec[4][8:0];
            r.din  = {m_prec[2], m_prec[3]};
            r.dout = {m_prec[0], m_prec[1]};
            if (m_prec[4][15:10] != 0) m_pad = 1;
            if (m_q.size() < 2) begin
                m_q.push_back(r);
                if (m_rc < CMAX) m_rc++;
                if (trig_en_i && r.addr == trig_addr_i) m_trig = 1;
            end else if (m_dc < CMAX) begin
                m_dc++;
            end
        end
        m_pend = 0;
        lane = {ser_wr_en_addr_i, ser_data_in_low_i, ser_data_in_high_i,
                ser_data_out_low_i, ser_data_out_high_i};
        if (m_shift) begin
            if (ser_valid_i) begin
                for (int k = 0; k < 5; k++) m_acc[k] = {m_acc[k][14:0], lane[k]};
                m_nb++;
                if (m_nb == 16) begin
                    m_pend = 1;
                    m_prec = m_acc;
                    m_nb   = 0;
                end
            end
        end else begin
            m_nb = 0;
            for (int k = 0; k < 5; k++) m_acc[k] = '0;
        end
        m_shift = debug_en_i;
    endtask

    always @(negedge clk_snn) begin
        if (cmp_on) begin
            chk("rec_valid", rec_valid_o, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("rec_we", rec_we_o, m_q[0].we);
                chk("rec_addr", rec_addr_o, m_q[0].addr);
                chk("rec_din", rec_data_in_o, m_q[0].din);
                chk("rec_dout", rec_data_out_o, m_q[0].dout);
            end
            chk("trig_hit", trig_hit_o, m_trig);
            chk("pad_err", pad_err_o, m_pad);
            chk("rec_count", rec_count_o, m_rc);
            chk("drop_count", drop_count_o, m_dc);
            chk("busy", busy_o, m_shift && m_nb != 0);
        end
    end

    task automatic tick();
        @(posedge clk_snn);
        model_step();
        #2;
    endtask

    task automatic do_reset();
        rst_i = 0; debug_en_i = 0; ser_valid_i = 0;
        tick();
        rst_i = 1;
    endtask

    task automatic send_frame(input logic [15:0] wr, input logic [31:0] din,
                              input logic [31:0] dout, input bit gap);
        for (int i = 15; i >= 0; i--) begin
            ser_data_out_high_i = dout[16+i];
            ser_data_out_low_i  = dout[i];
            ser_data_in_high_i  = din[16+i];
            ser_data_in_low_i   = din[i];
            ser_wr_en_addr_i    = wr[i];
            ser_valid_i         = 1;
            tick();
            if (gap) begin
                ser_valid_i = 0;
                tick();
            end
        end
        ser_valid_i = 0;
    endtask

    task automatic enable();
        debug_en_i = 1;
        tick();
    endtask

    logic [15:0] g_wr;
    logic [31:0] g_di, g_do;
    int          g_pos;

    initial begin
        do_reset();
        tick();
        cmp_on = 1;
        chk("lit_reset_valid", rec_valid_o, 1'b0);
        chk("lit_reset_cnt", rec_count_o, 0);

        // Basic frame, then the same frame with idle gaps between bits
        rec_ready_i = 1;
        enable();
        send_frame(16'h0205, 32'hDEADBEEF, 32'h12345678, 0);
        tick();
        chk("lit_f1_valid", rec_valid_o, 1'b1);
        chk("lit_f1_we", rec_we_o, 1'b1);
        chk("lit_f1_addr", rec_addr_o, 9'h005);
        chk("lit_f1_din", rec_data_in_o, 32'hDEADBEEF);
        chk("lit_f1_dout", rec_data_out_o, 32'h12345678);
        chk("lit_f1_cnt", rec_count_o, 1);
        send_frame(16'h0205, 32'hDEADBEEF, 32'h12345678, 1);
        chk("lit_f2_addr", rec_addr_o, 9'h005);
        chk("lit_f2_cnt", rec_count_o, 2);

        // Back-pressure: three frames into a 2-entry buffer
        do_reset();
        rec_ready_i = 0;
        enable();
        send_frame(16'h0011, 32'h1, 32'h2, 0);
        send_frame(16'h0022, 32'h3, 32'h4, 0);
        send_frame(16'h0033, 32'h5, 32'h6, 0);
        tick();
        chk("lit_bp_rc", rec_count_o, 2);
        chk("lit_bp_dc", drop_count_o, 1);
        chk("lit_bp_head", rec_addr_o, 9'h011);
        rec_ready_i = 1;
        tick();
        chk("lit_bp_second", rec_addr_o, 9'h022);
        tick();
        chk("lit_bp_empty", rec_valid_o, 1'b0);

        // Partial frame discarded when the collector is disabled
        do_reset();
        enable();
        send_frame(16'h0155, 32'hAAAA5555, 32'h5555AAAA, 0);
        do_reset();
        enable();
        for (int i = 0; i < 7; i++) begin
            ser_valid_i = 1; ser_wr_en_addr_i = 1; tick();
        end
        ser_valid_i = 0; debug_en_i = 0;
        tick(); tick();
        enable();
        send_frame(16'h0077, 32'hCAFEF00D, 32'h0BADBEEF, 0);
        tick();
        chk("lit_drop_cnt", rec_count_o, 1);
        chk("lit_drop_addr", rec_addr_o, 9'h077);

        // Trigger on address 0x0A3 only
        do_reset();
        trig_en_i = 1; trig_addr_i = 9'h0A3;
        enable();
        send_frame(16'h00A3, 32'h11, 32'h22, 0);
        tick();
        chk("lit_trig_hit", trig_hit_o, 1'b1);
        chk("lit_trig_valid", rec_valid_o, 1'b1);
        send_frame(16'h02A4, 32'h33, 32'h44, 0);
        tick();
        chk("lit_trig_nohit", trig_hit_o, 1'b0);

        // Sticky padding error
        do_reset();
        enable();
        send_frame(16'h8001, 32'h0, 32'h0, 0);
        tick();
        chk("lit_pad_set", pad_err_o, 1'b1);
        send_frame(16'h0001, 32'h0, 32'h0, 0);
        tick();
        chk("lit_pad_sticky", pad_err_o, 1'b1);
        do_reset();
        tick();
        chk("lit_pad_clear", pad_err_o, 1'b0);

        // Randomized traffic
        g_pos = 0;
        for (int c = 0; c < 4000; c++) begin
            if (g_pos == 0) begin
                g_wr = {($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'd0,
                        1'($urandom),
                        ($urandom_range(0, 2) == 0) ? 9'h0A3 : 9'($urandom)};
                g_di  = $urandom;
                g_do  = $urandom;
                g_pos = 16;
            end
            rst_i       = ($urandom_range(0, 999) != 0);
            debug_en_i  = ($urandom_range(0, 39) != 0);
            ser_valid_i = ($urandom_range(0, 3) != 0);
            rec_ready_i = ($urandom_range(0, 2) != 0);
            trig_en_i   = ($urandom_range(0, 3) != 0);
            trig_addr_i = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'h0A3;
            ser_data_out_high_i = g_do[16+g_pos-1];
            ser_data_out_low_i  = g_do[g_pos-1];
            ser_data_in_high_i  = g_di[16+g_pos-1];
            ser_data_in_low_i   = g_di[g_pos-1];
            ser_wr_en_addr_i    = g_wr[g_pos-1];
            if (ser_valid_i) g_pos--;
            tick();
        end
        rst_i = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
